// File: rtl/axis_frame_pkg.sv
// Shared types and constants for the control-packet driven frame unpacker.
package axis_frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSkip,
    StDrop,
    StCheck,
    StRun,
    StFlush
  } state_e;

  // Header nibble that identifies a valid control packet
  localparam logic [3:0] CNTRL_MAGIC = 4'hA;

  localparam int unsigned MAGIC_MSB  = 31;
  localparam int unsigned MAGIC_LSB  = 28;
  localparam int unsigned HEIGHT_MSB = 31;
  localparam int unsigned HEIGHT_LSB = 20;
  localparam int unsigned WIDTH_MSB  = 19;
  localparam int unsigned WIDTH_LSB  = 8;

  // Nominal control packet length; the parser itself trusts tlast only
  localparam int unsigned CNTRL_WORDS = 6;

endpackage

// File: rtl/axis_cntrl_frame_unpack_if.sv
// AXI-Stream bundle used for the control, MM2S and video streams.
interface axis_cntrl_frame_unpack_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register; full throughput, holds data while stalled.
module axis_out_reg #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_user_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_user_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i
);

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic                 user_q;
  logic                 last_q;

  // Empty slot or slot draining this cycle can take a new beat
  assign in_ready_o = !valid_q || out_ready_i;

  // Load on upstream accept, otherwise release the slot once downstream takes it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
      user_q  <= in_user_i;
      last_q  <= in_last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_user_o  = user_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/axis_cntrl_frame_unpack.sv
// Parses a DMA control packet for frame geometry, then re-emits one frame of MM2S
// beats as a video stream (tuser = start of frame, tlast = end of line).
// Optional statistics counters are enabled with the FRAME_UNPACK_STATS_EN macro.
module axis_cntrl_frame_unpack
  import axis_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNTRL_WIDTH = 32,
  parameter int unsigned MAX_DIM_W   = 12
) (
  input  logic                     s_axis_mm2s_aclk,
  input  logic                     s_axis_mm2s_aresetn,
  axis_cntrl_frame_unpack_if.slave  s_axis_cntrl,
  axis_cntrl_frame_unpack_if.slave  s_axis_mm2s,
  axis_cntrl_frame_unpack_if.master m_axis_video,
  output logic [MAX_DIM_W-1:0]     img_height,
  output logic [MAX_DIM_W-1:0]     img_width,
  output logic                     frame_busy,
  output logic                     frame_done,
`ifdef FRAME_UNPACK_STATS_EN
  output logic [15:0]              frame_count,
  output logic [7:0]               err_count,
`endif
  output logic                     cfg_err
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;

  state_e               state_q;
  logic                 cntrl_tready_q;
  logic                 frame_busy_q;
  logic                 frame_done_q;
  logic                 cfg_err_q;
  logic [MAX_DIM_W-1:0] shadow_h_q;
  logic [MAX_DIM_W-1:0] shadow_w_q;
  logic [MAX_DIM_W-1:0] img_height_q;
  logic [MAX_DIM_W-1:0] img_width_q;
  logic [MAX_DIM_W-1:0] line_beats_q;
  logic [MAX_DIM_W-1:0] col_q;
  logic [MAX_DIM_W-1:0] row_q;

  logic cntrl_acc;
  logic mm2s_acc;
  logic out_in_ready;
  logic run_valid;
  logic first_beat;
  logic last_col;
  logic last_row;
  logic hdr_ok;
  logic geom_bad;

  assign s_axis_cntrl.tready = cntrl_tready_q;
  assign cntrl_acc           = s_axis_cntrl.tvalid && cntrl_tready_q;

  // MM2S only flows in RUN, and only when the output slot can take the beat
  assign s_axis_mm2s.tready = (state_q == StRun) && out_in_ready;
  assign mm2s_acc           = s_axis_mm2s.tvalid && s_axis_mm2s.tready;
  assign run_valid          = s_axis_mm2s.tvalid && (state_q == StRun);

  assign first_beat = (row_q == '0) && (col_q == '0);
  assign last_col   = (col_q == line_beats_q - 1'b1);
  assign last_row   = (row_q == img_height_q - 1'b1);

  assign hdr_ok   = (s_axis_cntrl.tdata[MAGIC_MSB:MAGIC_LSB] == CNTRL_MAGIC);
  assign geom_bad = (shadow_h_q == '0) || (shadow_w_q == '0) ||
                    ((32'(shadow_w_q) % Bytes) != 32'd0);

  // Control parser, geometry check and frame beat counters
  always_ff @(posedge s_axis_mm2s_aclk) begin
    if (!s_axis_mm2s_aresetn) begin
      state_q        <= StIdle;
      cntrl_tready_q <= 1'b0;
      frame_busy_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      cfg_err_q      <= 1'b0;
      shadow_h_q     <= '0;
      shadow_w_q     <= '0;
      img_height_q   <= '0;
      img_width_q    <= '0;
      line_beats_q   <= '0;
      col_q          <= '0;
      row_q          <= '0;
    end else begin
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Ready comes up one cycle after reset release
          cntrl_tready_q <= 1'b1;
          if (cntrl_acc) begin
            if (s_axis_cntrl.tlast) begin
              cfg_err_q <= 1'b1;
            end else if (hdr_ok) begin
              state_q <= StHdr;
            end else begin
              state_q <= StDrop;
            end
          end
        end
        StHdr: begin
          if (cntrl_acc) begin
            shadow_h_q <= s_axis_cntrl.tdata[HEIGHT_MSB:HEIGHT_LSB];
            shadow_w_q <= s_axis_cntrl.tdata[WIDTH_MSB:WIDTH_LSB];
            if (s_axis_cntrl.tlast) begin
              state_q        <= StCheck;
              cntrl_tready_q <= 1'b0;
            end else begin
              state_q <= StSkip;
            end
          end
        end
        StSkip: begin
          if (cntrl_acc && s_axis_cntrl.tlast) begin
            state_q        <= StCheck;
            cntrl_tready_q <= 1'b0;
          end
        end
        StDrop: begin
          if (cntrl_acc && s_axis_cntrl.tlast) begin
            cfg_err_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StCheck: begin
          if (geom_bad) begin
            cfg_err_q      <= 1'b1;
            cntrl_tready_q <= 1'b1;
            state_q        <= StIdle;
          end else begin
            img_height_q <= shadow_h_q;
            img_width_q  <= shadow_w_q;
            line_beats_q <= MAX_DIM_W'(32'(shadow_w_q) / Bytes);
            col_q        <= '0;
            row_q        <= '0;
            frame_busy_q <= 1'b1;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (mm2s_acc) begin
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
              if (last_row) begin
                frame_busy_q <= 1'b0;
                state_q      <= StFlush;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StFlush: begin
          if (m_axis_video.tvalid && m_axis_video.tready) begin
            frame_done_q   <= 1'b1;
            cntrl_tready_q <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_out_reg #(
    .DataWidth(DATA_WIDTH)
  ) u_out_reg (
    .clk_i      (s_axis_mm2s_aclk),
    .rst_ni     (s_axis_mm2s_aresetn),
    .in_valid_i (run_valid),
    .in_data_i  (s_axis_mm2s.tdata),
    .in_user_i  (first_beat),
    .in_last_i  (last_col),
    .in_ready_o (out_in_ready),
    .out_valid_o(m_axis_video.tvalid),
    .out_data_o (m_axis_video.tdata),
    .out_user_o (m_axis_video.tuser),
    .out_last_o (m_axis_video.tlast),
    .out_ready_i(m_axis_video.tready)
  );

  assign m_axis_video.tkeep = '1;

  assign img_height = img_height_q;
  assign img_width  = img_width_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

`ifdef FRAME_UNPACK_STATS_EN
  logic [15:0] frame_count_q;
  logic [7:0]  err_count_q;

  // Frame counter wraps; error counter saturates
  always_ff @(posedge s_axis_mm2s_aclk) begin
    if (!s_axis_mm2s_aresetn) begin
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      if (frame_done_q) begin
        frame_count_q <= frame_count_q + 1'b1;
      end
      if (cfg_err_q && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`endif

endmodule

// File: doc/axis_cntrl_frame_unpack.md
Name: axis_cntrl_frame_unpack

Overview:
- Downstream consumer of the DMA MM2S control and data streams.
- Parses the 6-word control packet to latch image height and width.
- Accepts exactly one frame of MM2S data beats and re-emits them as a framed video AXI-Stream: tuser marks start-of-frame, tlast marks end-of-line.
- Frame geometry comes only from the control packet; the MM2S stream carries no usable tlast.

Parameters:
- DATA_WIDTH, 32, MM2S and video tdata width; one beat = DATA_WIDTH/8 8-bit pixels.
- CNTRL_WIDTH, 32, control stream tdata width.
- MAX_DIM_W, 12, bit width of the height and width fields.

Ports:
- s_axis_mm2s_aclk  in  1  sole clock
- s_axis_mm2s_aresetn  in  1  synchronous active-low reset
- s_axis_cntrl_tvalid  in  1  control beat valid
- s_axis_cntrl_tdata  in  CNTRL_WIDTH  control word
- s_axis_cntrl_tkeep  in  CNTRL_WIDTH/8  ignored
- s_axis_cntrl_tlast  in  1  last control word
- s_axis_cntrl_tready  out  1  control accept
- s_axis_mm2s_tvalid  in  1  data beat valid
- s_axis_mm2s_tdata  in  DATA_WIDTH  pixel data
- s_axis_mm2s_tkeep  in  DATA_WIDTH/8  ignored
- s_axis_mm2s_tlast  in  1  ignored
- s_axis_mm2s_tready  out  1  data accept
- m_axis_video_tvalid  out  1  video beat valid
- m_axis_video_tdata  out  DATA_WIDTH  pixel data
- m_axis_video_tuser  out  1  first beat of frame
- m_axis_video_tlast  out  1  last beat of each line
- m_axis_video_tready  in  1  downstream accept
- img_height  out  MAX_DIM_W  latched height
- img_width  out  MAX_DIM_W  latched width, in pixels
- frame_busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted downstream
- cfg_err  out  1  one-cycle pulse on a rejected control packet

Behaviour:
- Reset is synchronous, active-low, one clock. All outputs are 0 on reset, img_height and img_width included. State goes to IDLE.
- Control word format:
  - word0 header: bits [31:28] must equal 4'hA.
  - word1: height = [31:20], width = [19:8], [7:0] reserved.
  - words 2..N ignored; the packet ends on tlast.
- States:
  - IDLE: cntrl_tready=1, mm2s_tready=0. On an accepted word0: header OK -> HDR; header bad -> DROP. If word0 also carries tlast -> cfg_err pulse, stay IDLE.
  - HDR: cntrl_tready=1. On an accepted word1, latch height and width into shadow registers. Then -> SKIP, or -> CHECK if tlast.
  - SKIP: cntrl_tready=1. Discard words until tlast, then -> CHECK.
  - DROP: cntrl_tready=1. Discard until tlast, pulse cfg_err, -> IDLE.
  - CHECK (1 cycle): cntrl_tready=0.
    - Reject (cfg_err pulse, -> IDLE) if height==0, width==0, or width is not a multiple of DATA_WIDTH/8.
    - Otherwise copy shadow -> img_height/img_width, compute line_beats = width/(DATA_WIDTH/8), clear col/row counters, -> RUN.
  - RUN: cntrl_tready=0; frame_busy=1.
    - s_axis_mm2s_tready = !m_axis_video_tvalid || m_axis_video_tready (single output register stage, no bubble under continuous flow).
    - Each accepted beat is registered to the output with:
      - tuser = (row==0 && col==0)
      - tlast = (col==line_beats-1)
    - col wraps to 0 at line_beats-1 and row then increments.
    - When the beat with row==height-1 and col==line_beats-1 is accepted upstream, mm2s_tready drops and the state -> FLUSH.
  - FLUSH: wait until the output register drains (tvalid && tready). Then pulse frame_done and -> IDLE.
- Latency: 1 cycle from mm2s accept to m_axis_video_tvalid.
- Output tvalid and tdata hold stable while tready=0.
- Control words arriving during RUN/FLUSH are not accepted (tready=0).
- Reset mid-frame: output tvalid drops the next cycle, counters clear, partial frame abandoned.
- Counter widths: col and row are MAX_DIM_W bits; no overflow is possible given the CHECK rules.

Optional Feature:
- Macro: FRAME_UNPACK_STATS_EN.
- When defined, two extra output ports are added:
  - frame_count[15:0]: increments on each frame_done, wraps at 0xFFFF -> 0.
  - err_count[7:0]: increments on each cfg_err, saturates at 0xFF.
  - Both reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package axis_frame_pkg holds:
  - the state enum (IDLE, HDR, SKIP, DROP, CHECK, RUN, FLUSH)
  - CNTRL_MAGIC = 4'hA
  - field bit positions (HEIGHT_MSB/LSB, WIDTH_MSB/LSB)
  - CNTRL_WORDS = 6
- One natural sub-module, axis_out_reg: the single-stage output register with tready propagation.
- The control parser and the counters stay in the top.

Test Plan:
- Control packet {A0000000, {12'd4,12'd8,8'd0}, A0000003..A0000006 (tlast)}, then 8 data beats 1..8, tready=1 -> img_height=4, img_width=8, line_beats=2; tuser on beat 1 only; tlast on beats 2,4,6,8; frame_done 1 cycle after beat 8 output; mm2s_tready=0 before control is complete.
- Same frame with m_axis_video_tready toggling 1,0,0,1 -> no lost or duplicated beats, tdata stable while stalled, frame_done only after beat 8 accepted.
- Header 0x50000000 six-word packet -> cfg_err pulse at tlast, state IDLE, img_width/img_height unchanged, mm2s_tready stays 0.
- Width 6 (not a multiple of 4), and separately height 0 -> cfg_err pulse, no RUN entry.
- Reset asserted after 3 of 8 beats -> outputs 0 next cycle; a new control packet and a full frame then complete normally.
- With FRAME_UNPACK_STATS_EN: 3 good frames plus 1 bad header -> frame_count=3, err_count=1.
